// File: rtl/jtag_pkg.sv
// JTAG TAP shared definitions: TAP state codes
// and instruction opcodes.
package jtag_pkg;

  typedef logic [3:0] tap_state_t;

  localparam tap_state_t S_EXIT2_DR   = 4'h0;
  localparam tap_state_t S_EXIT1_DR   = 4'h1;
  localparam tap_state_t S_SHIFT_DR   = 4'h2;
  localparam tap_state_t S_PAUSE_DR   = 4'h3;
  localparam tap_state_t S_SELECT_IR  = 4'h4;
  localparam tap_state_t S_UPDATE_DR  = 4'h5;
  localparam tap_state_t S_CAPTURE_DR = 4'h6;
  localparam tap_state_t S_SELECT_DR  = 4'h7;
  localparam tap_state_t S_EXIT2_IR   = 4'h8;
  localparam tap_state_t S_EXIT1_IR   = 4'h9;
  localparam tap_state_t S_SHIFT_IR   = 4'hA;
  localparam tap_state_t S_PAUSE_IR   = 4'hB;
  localparam tap_state_t S_RTI        = 4'hC;
  localparam tap_state_t S_UPDATE_IR  = 4'hD;
  localparam tap_state_t S_CAPTURE_IR = 4'hE;
  localparam tap_state_t S_TLR        = 4'hF;

  localparam int unsigned INSTR_EXTEST = 0;
  localparam int unsigned INSTR_IDCODE = 1;
  localparam int unsigned INSTR_SAMPLE = 2;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state FSM
// plus capture/shift/update strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state,
  output logic       tlr_strobe,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_t next_state;

  always_ff @(posedge tck) begin
    if (reset) state <= S_TLR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_TLR:        next_state = tms ? S_TLR       : S_RTI;
      S_RTI:        next_state = tms ? S_SELECT_DR : S_RTI;
      S_SELECT_DR:  next_state = tms ? S_SELECT_IR : S_CAPTURE_DR;
      S_CAPTURE_DR: next_state = tms ? S_EXIT1_DR  : S_SHIFT_DR;
      S_SHIFT_DR:   next_state = tms ? S_EXIT1_DR  : S_SHIFT_DR;
      S_EXIT1_DR:   next_state = tms ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:   next_state = tms ? S_EXIT2_DR  : S_PAUSE_DR;
      S_EXIT2_DR:   next_state = tms ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR:  next_state = tms ? S_SELECT_DR : S_RTI;
      S_SELECT_IR:  next_state = tms ? S_TLR       : S_CAPTURE_IR;
      S_CAPTURE_IR: next_state = tms ? S_EXIT1_IR  : S_SHIFT_IR;
      S_SHIFT_IR:   next_state = tms ? S_EXIT1_IR  : S_SHIFT_IR;
      S_EXIT1_IR:   next_state = tms ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:   next_state = tms ? S_EXIT2_IR  : S_PAUSE_IR;
      S_EXIT2_IR:   next_state = tms ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR:  next_state = tms ? S_SELECT_DR : S_RTI;
    endcase
  end

  // Instruction reload fires both while in TLR and on the edge entering it
  assign tlr_strobe = (state == S_TLR) || (next_state == S_TLR);
  assign capture_dr = (state == S_CAPTURE_DR);
  assign shift_dr   = (state == S_SHIFT_DR);
  assign update_dr  = (state == S_UPDATE_DR);
  assign capture_ir = (state == S_CAPTURE_IR);
  assign shift_ir   = (state == S_SHIFT_IR);
  assign update_ir  = (state == S_UPDATE_IR);

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder: IR, BSR, bypass and IDCODE
// registers with the TDO mux around jtag_tap_fsm.
module jtag_tap_responder
  import jtag_pkg::*;
#(
  parameter int          BSC_Reg_size = 253,
  parameter int          IR_size      = 3,
  parameter logic [31:0] IDCODE_value = 32'h1000_0001
) (
  input  logic                    TCK,
  input  logic                    reset,
  input  logic                    TMS,
  input  logic                    TDI,
  output logic                    TDO,
  output logic                    enableTDO,
  input  logic [BSC_Reg_size-1:0] scan_in_data,
  output logic [BSC_Reg_size-1:0] scan_out_data,
  output logic                    extest_mode,
  output logic [IR_size-1:0]      ir_current
);

  localparam logic [IR_size-1:0] IR_EXTEST =
    IR_size'(INSTR_EXTEST);
  localparam logic [IR_size-1:0] IR_IDCODE =
    IR_size'(INSTR_IDCODE);
  localparam logic [IR_size-1:0] IR_SAMPLE =
    IR_size'(INSTR_SAMPLE);
  localparam logic [IR_size-1:0] IR_CAPTURE =
    IR_size'(2'b01);

  tap_state_t state;
  logic tlr_strobe;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  logic [IR_size-1:0]      ir_sr;
  logic [BSC_Reg_size-1:0] bsr;
  logic [31:0]             id_sr;
  logic                    byp;
  logic                    sel_bsr;
  logic                    sel_id;

  jtag_tap_fsm u_fsm (
    .tck        (TCK),
    .reset      (reset),
    .tms        (TMS),
    .state      (state),
    .tlr_strobe (tlr_strobe),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  // Unknown opcodes fall through to bypass
  assign sel_bsr = (ir_current == IR_EXTEST) ||
                   (ir_current == IR_SAMPLE);
  assign sel_id  = (ir_current == IR_IDCODE);

  always_ff @(posedge TCK) begin
    if (reset) begin
      ir_sr         <= '0;
      ir_current    <= IR_IDCODE;
      bsr           <= '0;
      id_sr         <= '0;
      byp           <= 1'b0;
      scan_out_data <= '0;
    end else begin
      if (capture_ir)
        ir_sr <= IR_CAPTURE;
      else if (shift_ir)
        ir_sr <= {TDI, ir_sr[IR_size-1:1]};

      if (tlr_strobe)
        ir_current <= IR_IDCODE;
      else if (update_ir)
        ir_current <= ir_sr;

      if (capture_dr) begin
        unique case (1'b1)
          sel_bsr: bsr   <= scan_in_data;
          sel_id:  id_sr <= IDCODE_value;
          default: byp   <= 1'b0;
        endcase
      end else if (shift_dr) begin
        unique case (1'b1)
          sel_bsr: bsr   <= {TDI, bsr[BSC_Reg_size-1:1]};
          sel_id:  id_sr <= {TDI, id_sr[31:1]};
          default: byp   <= TDI;
        endcase
      end

      if (update_dr && sel_bsr)
        scan_out_data <= bsr;
    end
  end

  assign enableTDO = (state == S_SHIFT_DR) ||
                     (state == S_SHIFT_IR);
  assign extest_mode = (ir_current == IR_EXTEST);

  always_comb begin
    TDO = 1'b0;
    if (state == S_SHIFT_IR) begin
      TDO = ir_sr[0];
    end else if (state == S_SHIFT_DR) begin
      unique case (1'b1)
        sel_bsr: TDO = bsr[0];
        sel_id:  TDO = id_sr[0];
        default: TDO = byp;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: expected
// TDO bits are queued per scan, a monitor pops them.
module tb_jtag_tap_responder;

  localparam int L = 253;
  localparam logic [31:0] IDC = 32'h1000_0001;

  logic TCK = 1'b0;
  logic reset = 1'b1;
  logic TMS = 1'b1;
  logic TDI = 1'b0;
  logic [L-1:0] scan_in_data = '0;
  logic TDO, enableTDO, extest_mode;
  logic [L-1:0] scan_out_data;
  logic [2:0] ir_current;

  jtag_tap_responder dut (
    .TCK           (TCK),
    .reset         (reset),
    .TMS           (TMS),
    .TDI           (TDI),
    .TDO           (TDO),
    .enableTDO     (enableTDO),
    .scan_in_data  (scan_in_data),
    .scan_out_data (scan_out_data),
    .extest_mode   (extest_mode),
    .ir_current    (ir_current)
  );

  always #5 TCK = ~TCK;

  int n_vec = 0;
  int n_bad = 0;
  bit exp_q[$];
  bit mon_on = 1'b0;
  bit e_bit;
  logic [2:0] m_ir;
  logic [L-1:0] m_out;
  logic [511:0] d;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge TCK) begin
    if (mon_on) begin
      if (enableTDO) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tdo_extra: got %0b want none", TDO);
        end else begin
          e_bit = exp_q.pop_front();
          chk("tdo", 256'(TDO), 256'(e_bit));
        end
      end else begin
        chk("tdo_idle", 256'(TDO), 256'd0);
      end
    end
  end

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Expected TDO = captured bits followed by TDI bits,
  // register afterwards holds the last len bits of that
  task automatic scan(input bit is_ir, input int n,
                      input logic [511:0] din,
                      input int pause_at);
    bit q[$];
    int len;
    logic [L-1:0] cap;
    q = {};
    if (is_ir) begin
      len = 3;
      cap = L'(1);
    end else if (m_ir == 0 || m_ir == 2) begin
      len = L;
      cap = scan_in_data;
    end else if (m_ir == 1) begin
      len = 32;
      cap = L'(IDC);
    end else begin
      len = 1;
      cap = '0;
    end
    for (int i = 0; i < len; i++) q.push_back(cap[i]);
    for (int i = 0; i < n; i++) q.push_back(din[i]);
    for (int i = 0; i < n; i++) exp_q.push_back(q[i]);
    tick(1, 0);
    if (is_ir) tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1 || i == pause_at - 1, din[i]);
      if (i == pause_at - 1 && i != n - 1) begin
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
      end
    end
    tick(1, 0);
    tick(0, 0);
    if (is_ir) begin
      m_ir = {q[n + 2], q[n + 1], q[n]};
    end else if (m_ir == 0 || m_ir == 2) begin
      for (int j = 0; j < L; j++) m_out[j] = q[n + j];
    end
  endtask

  task automatic post(input string tag);
    chk({tag, "_ir"}, 256'(ir_current), 256'(m_ir));
    chk({tag, "_ext"}, 256'(extest_mode),
        256'(m_ir == 3'd0));
    chk({tag, "_out"}, 256'(scan_out_data), 256'(m_out));
  endtask

  task automatic rand_d();
    for (int i = 0; i < 512; i++)
      d[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_scan_in();
    for (int i = 0; i < L; i++)
      scan_in_data[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ir = 3'd1;
    m_out = '0;
    reset = 1'b1;
    tick(1, 0);
    tick(1, 0);
    mon_on = 1'b1;
    chk("rst_ir", 256'(ir_current), 256'd1);
    chk("rst_out", 256'(scan_out_data), 256'd0);
    chk("rst_ext", 256'(extest_mode), 256'd0);
    chk("rst_en", 256'(enableTDO), 256'd0);
    reset = 1'b0;
    tick(0, 0);
    chk("rti_ir", 256'(ir_current), 256'd1);

    rand_d();
    scan(0, 32, d, 0);
    post("idcode");

    scan(1, 3, 512'h7, 0);
    post("ir_byp");
    scan(0, 4, 512'hD, 0);
    post("byp");

    scan_in_data = L'(253'h5A5);
    scan(1, 3, 512'h2, 0);
    rand_d();
    scan(0, L, d, 0);
    post("sample");

    scan(1, 3, 512'h0, 0);
    post("extest");
    rand_scan_in();
    rand_d();
    scan(0, 40, d, 17);
    post("extest_pause");

    scan(1, 3, 512'h7, 0);
    post("ir_byp2");
    exp_q.push_back(1'b0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    repeat (5) tick(1, 0);
    m_ir = 3'd1;
    post("tms_tlr");
    chk("tms_tlr_en", 256'(enableTDO), 256'd0);
    tick(0, 0);

    scan(1, 3, 512'h2, 0);
    rand_scan_in();
    exp_q.push_back(scan_in_data[0]);
    exp_q.push_back(scan_in_data[1]);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 1);
    tick(1, 1);
    tick(0, 0);
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    m_ir = 3'd1;
    m_out = '0;
    post("pause_rst");
    chk("pause_rst_en", 256'(enableTDO), 256'd0);
    chk("pause_rst_tdo", 256'(TDO), 256'd0);
    tick(0, 0);

    for (int k = 0; k < 10; k++) begin
      scan(1, 3, 512'($urandom_range(0, 7)), 0);
      post("rnd_ir");
      rand_scan_in();
      rand_d();
      scan(0, $urandom_range(1, 300), d,
           $urandom_range(0, 3) == 0 ?
             $urandom_range(1, 20) : 0);
      post("rnd_dr");
    end

    chk("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
